sat_addsub_pipe: RTL and testbench

SAT_ADDSUB_PIPE -- requirements
Module: sat_addsub_pipe

---
 rtl/sat_alu_pkg.sv | 27 ++
 rtl/sat_addsub_pipe_cla_slice.sv | 44 ++++
 rtl/sat_addsub_pipe.sv | 169 ++++++++++++++++
 tb/tb_sat_addsub_pipe.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sat_alu_pkg.sv
// Shared mode encodings and saturation-constant helpers for the saturating add/sub datapath.
package sat_alu_pkg;

    localparam logic [1:0] MODE_FULL_WRAP = 2'b00;
    localparam logic [1:0] MODE_FULL_SAT  = 2'b01;
    localparam logic [1:0] MODE_PACK_SAT  = 2'b10;
    localparam logic [1:0] MODE_PACK_WRAP = 2'b11;

    function automatic logic mode_is_packed(input logic [1:0] m);
        return (m == MODE_PACK_SAT) || (m == MODE_PACK_WRAP);
    endfunction

    function automatic logic mode_is_sat(input logic [1:0] m);
        return (m == MODE_FULL_SAT) || (m == MODE_PACK_SAT);
    endfunction

    // Largest positive two's-complement value of width w (0111..1), zero-extended to 64 bits.
    function automatic logic [63:0] sat_pos(input int unsigned w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    // Most negative two's-complement value of width w (1000..0), zero-extended to 64 bits.
    function automatic logic [63:0] sat_neg(input int unsigned w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/sat_addsub_pipe_cla_slice.sv
// Combinational LANE_W-bit carry-lookahead adder slice with carry-out and carry-into-MSB.
module cla_slice #(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         c_i,
    output logic [W-1:0] sum_o,
    output logic         c_o,
    output logic         c_msb_o
);

    logic [W-1:0] g;
    logic [W-1:0] p;
    logic [W:0]   c;

    assign g = a_i & b_i;
    assign p = a_i ^ b_i;

    // Each carry is the flat lookahead term: g[i] | p[i]g[i-1] | ... | p[i..0]c_i.
    always_comb begin : lookahead
        logic acc;
        logic pp;
        c    = '0;
        c[0] = c_i;
        acc  = 1'b0;
        pp   = 1'b0;
        for (int unsigned i = 0; i < W; i++) begin
            acc = g[i];
            pp  = p[i];
            for (int unsigned j = 0; j < i; j++) begin
                acc = acc | (pp & g[i-1-j]);
                pp  = pp & p[i-1-j];
            end
            acc    = acc | (pp & c_i);
            c[i+1] = acc;
        end
    end

    assign sum_o   = p ^ c[W-1:0];
    assign c_o     = c[W];
    assign c_msb_o = c[W-1];

endmodule

// File: rtl/sat_addsub_pipe.sv
// Two-stage saturating/wrapping add-subtract pipeline, full-word or packed-lane, with valid/ready.
module sat_addsub_pipe
    import sat_alu_pkg::*;
#(
    parameter  int unsigned WIDTH  = 16,
    parameter  int unsigned LANE_W = 4,
    localparam int unsigned NL     = WIDTH / LANE_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [NL-1:0]    lane_ovf,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);

    if ((WIDTH % LANE_W) != 0) begin : g_bad_multiple
        $error("sat_addsub_pipe: WIDTH must be a multiple of LANE_W");
    end
    if ((WIDTH < 4) || (WIDTH > 64)) begin : g_bad_width
        $error("sat_addsub_pipe: WIDTH must be within 4..64");
    end
    if ((LANE_W != 4) && (LANE_W != 8) && (LANE_W != 16)) begin : g_bad_lane
        $error("sat_addsub_pipe: LANE_W must be 4, 8 or 16");
    end

    localparam logic [63:0] LANE_POS64 = sat_pos(LANE_W);
    localparam logic [63:0] LANE_NEG64 = sat_neg(LANE_W);
    localparam logic [63:0] WORD_POS64 = sat_pos(WIDTH);
    localparam logic [63:0] WORD_NEG64 = sat_neg(WIDTH);

    // ---------------- Stage 1 datapath ----------------
    logic             packed_in;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] sum_raw;
    logic [NL-1:0]    ovf_raw;
    logic [NL-1:0]    s1_ovf_d;

    assign packed_in = mode_is_packed(mode);
    assign b_eff     = sub ? ~b : b;

    // Full modes chain slice carries; packed lanes each take sub as their carry-in.
    for (genvar k = 0; k < NL; k++) begin : g_lane
        logic cin_l;
        logic cout_l;
        logic cmsb_l;
        if (k == 0) begin : g_first
            assign cin_l = packed_in ? sub : (sub | cin);
        end else begin : g_chain
            assign cin_l = packed_in ? sub : g_lane[k-1].cout_l;
        end
        cla_slice #(.W(LANE_W)) u_slice (
            .a_i     (a[k*LANE_W +: LANE_W]),
            .b_i     (b_eff[k*LANE_W +: LANE_W]),
            .c_i     (cin_l),
            .sum_o   (sum_raw[k*LANE_W +: LANE_W]),
            .c_o     (cout_l),
            .c_msb_o (cmsb_l)
        );
        assign ovf_raw[k] = cmsb_l ^ cout_l;
    end

    // Only the top lane's overflow describes the word in full modes.
    always_comb begin
        s1_ovf_d = '0;
        if (packed_in) begin
            s1_ovf_d = ovf_raw;
        end else begin
            s1_ovf_d[NL-1] = ovf_raw[NL-1];
        end
    end

    // ---------------- Handshake ----------------
    logic s1_v_q;
    logic s2_v_q;
    logic s2_adv;

    assign s2_adv   = !s2_v_q || out_ready;
    assign in_ready = !s1_v_q || s2_adv;

    logic [WIDTH-1:0] s1_sum_q;
    logic [NL-1:0]    s1_ovf_q;
    logic             s1_sat_q;
    logic             s1_packed_q;

    // Stage 1 register: loads the raw sum and overflow bits on accept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_v_q      <= 1'b0;
            s1_sum_q    <= '0;
            s1_ovf_q    <= '0;
            s1_sat_q    <= 1'b0;
            s1_packed_q <= 1'b0;
        end else if (in_ready) begin
            s1_v_q <= in_valid;
            if (in_valid) begin
                s1_sum_q    <= sum_raw;
                s1_ovf_q    <= s1_ovf_d;
                s1_sat_q    <= mode_is_sat(mode);
                s1_packed_q <= packed_in;
            end
        end
    end

    // ---------------- Stage 2 datapath ----------------
    logic [WIDTH-1:0] s2_res_d;

    // Overflow flips the sign, so a raw MSB of 1 means the true value was positive.
    always_comb begin
        s2_res_d = s1_sum_q;
        if (s1_sat_q) begin
            if (s1_packed_q) begin
                for (int unsigned k = 0; k < NL; k++) begin
                    if (s1_ovf_q[k]) begin
                        s2_res_d[k*LANE_W +: LANE_W] = s1_sum_q[k*LANE_W + LANE_W - 1]
                            ? LANE_POS64[LANE_W-1:0] : LANE_NEG64[LANE_W-1:0];
                    end
                end
            end else if (s1_ovf_q[NL-1]) begin
                s2_res_d = s1_sum_q[WIDTH-1] ? WORD_POS64[WIDTH-1:0] : WORD_NEG64[WIDTH-1:0];
            end
        end
    end

    logic [WIDTH-1:0] result_q;
    logic [NL-1:0]    lane_ovf_q;
    logic             ovf_q;
    logic             zero_q;
    logic             neg_q;

    // Stage 2 register: holds the final result and flags until consumed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_v_q     <= 1'b0;
            result_q   <= '0;
            lane_ovf_q <= '0;
            ovf_q      <= 1'b0;
            zero_q     <= 1'b0;
            neg_q      <= 1'b0;
        end else if (s2_adv) begin
            s2_v_q <= s1_v_q;
            if (s1_v_q) begin
                result_q   <= s2_res_d;
                lane_ovf_q <= s1_ovf_q;
                ovf_q      <= |s1_ovf_q;
                zero_q     <= (s2_res_d == '0);
                neg_q      <= s2_res_d[WIDTH-1];
            end
        end
    end

    assign out_valid = s2_v_q;
    assign result    = result_q;
    assign lane_ovf  = lane_ovf_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;
    assign neg       = neg_q;

endmodule

// File: tb/tb_sat_addsub_pipe.sv
// Self-checking bench for sat_addsub_pipe (WIDTH=16, LANE_W=4) against an arithmetic reference model.
module tb_sat_addsub_pipe;
    import sat_alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [1:0]  mode;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic [3:0]  lane_ovf;
    logic        ovf;
    logic        zero;
    logic        neg;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sat_addsub_pipe #(.WIDTH(16), .LANE_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .lane_ovf  (lane_ovf),
        .ovf       (ovf),
        .zero      (zero),
        .neg       (neg)
    );

    typedef struct packed {
        logic [15:0] r;
        logic [3:0]  lo;
        logic        ovf;
        logic        zero;
        logic        neg;
    } exp_t;

    exp_t q[$];

    // Reference: true signed arithmetic, range-checked, then clamped or wrapped.
    function automatic exp_t model(input logic [15:0] ma, input logic [15:0] mb,
                                   input logic mc, input logic ms, input logic [1:0] mm);
        exp_t e;
        int   sa;
        int   sb;
        int   t;
        logic [3:0] la;
        logic [3:0] lb;
        e = '0;
        if (mm == MODE_FULL_WRAP || mm == MODE_FULL_SAT) begin
            sa = int'($signed(ma));
            sb = int'($signed(mb));
            t  = ms ? (sa - sb) : (sa + sb + int'(mc));
            if (t > 32767 || t < -32768) begin
                e.lo[3] = 1'b1;
                if (mm == MODE_FULL_SAT) t = (t > 0) ? 32767 : -32768;
            end
            e.r = t[15:0];
        end else begin
            for (int l = 0; l < 4; l++) begin
                la = ma[4*l +: 4];
                lb = mb[4*l +: 4];
                sa = int'($signed(la));
                sb = int'($signed(lb));
                t  = ms ? (sa - sb) : (sa + sb);
                if (t > 7 || t < -8) begin
                    e.lo[l] = 1'b1;
                    if (mm == MODE_PACK_SAT) t = (t > 0) ? 7 : -8;
                end
                e.r[4*l +: 4] = t[3:0];
            end
        end
        e.ovf  = |e.lo;
        e.zero = (e.r == 16'h0000);
        e.neg  = e.r[15];
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [15:0] ia, input logic [15:0] ib, input logic ic,
                          input logic is, input logic [1:0] im, input logic iv);
        a        = ia;
        b        = ib;
        cin      = ic;
        sub      = is;
        mode     = im;
        in_valid = iv;
    endtask

    task automatic set_rand(input logic iv);
        set_in(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
               2'($urandom_range(0, 3)), iv);
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        out_ready = 1'b1;
        set_in(16'h1234, 16'h4321, 1'b0, 1'b0, MODE_FULL_WRAP, 1'b1);
        repeat (3) tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid got=%b exp=0", out_valid);
        end
        checks++;
        if ({result, lane_ovf, ovf, zero, neg} !== 23'd0) begin
            errors++;
            $display("FAIL reset_outputs got result=%h lane_ovf=%b ovf=%b zero=%b neg=%b exp all 0",
                     result, lane_ovf, ovf, zero, neg);
        end
        in_valid = 1'b0;
        rst_n    = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got=%b exp=1", in_ready);
        end
    endtask

    typedef struct {
        logic [15:0] va;
        logic [15:0] vb;
        logic        vc;
        logic        vs;
        logic [1:0]  vm;
        logic [15:0] er;
        logic [3:0]  elo;
    } vec_t;

    task automatic test_directed();
        vec_t v[10];
        v[0] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, MODE_FULL_SAT,  16'h7FFF, 4'b1000};
        v[1] = '{16'h8000, 16'h0001, 1'b0, 1'b1, MODE_FULL_SAT,  16'h8000, 4'b1000};
        v[2] = '{16'h8000, 16'h0001, 1'b0, 1'b1, MODE_FULL_WRAP, 16'h7FFF, 4'b1000};
        v[3] = '{16'h7835, 16'h1812, 1'b0, 1'b0, MODE_PACK_SAT,  16'h7847, 4'b1100};
        v[4] = '{16'h7835, 16'h1812, 1'b0, 1'b0, MODE_PACK_WRAP, 16'h8047, 4'b1100};
        v[5] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, MODE_FULL_WRAP, 16'h0000, 4'b0000};
        v[6] = '{16'h0007, 16'h0000, 1'b1, 1'b0, MODE_PACK_WRAP, 16'h0007, 4'b0000};
        v[7] = '{16'h0005, 16'h0003, 1'b1, 1'b1, MODE_FULL_WRAP, 16'h0002, 4'b0000};
        v[8] = '{16'h8000, 16'h1000, 1'b0, 1'b1, MODE_PACK_SAT,  16'h8000, 4'b1000};
        v[9] = '{16'h8000, 16'hFFFF, 1'b0, 1'b0, MODE_FULL_SAT,  16'h8000, 4'b1000};
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            set_in(v[i].va, v[i].vb, v[i].vc, v[i].vs, v[i].vm, 1'b1);
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL dir%0d_in_ready got=%b exp=1", i, in_ready);
            end
            tick();
            in_valid = 1'b0;
            #1;
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL dir%0d_early_out got=%b exp=0", i, out_valid);
            end
            tick();
            checks++;
            if (out_valid !== 1'b1 || result !== v[i].er || lane_ovf !== v[i].elo ||
                ovf !== (|v[i].elo) || zero !== (v[i].er == 16'h0) || neg !== v[i].er[15]) begin
                errors++;
                $display("FAIL dir%0d got v=%b r=%h lo=%b o=%b z=%b n=%b exp v=1 r=%h lo=%b o=%b z=%b n=%b",
                         i, out_valid, result, lane_ovf, ovf, zero, neg, v[i].er, v[i].elo,
                         |v[i].elo, v[i].er == 16'h0, v[i].er[15]);
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        exp_t x[3];
        logic [15:0] xa[3];
        logic [15:0] xb[3];
        logic        xs[3];
        logic [1:0]  xm[3];
        for (int i = 0; i < 3; i++) begin
            xa[i] = 16'($urandom);
            xb[i] = 16'($urandom);
            xs[i] = 1'($urandom);
            xm[i] = 2'($urandom_range(0, 3));
            x[i]  = model(xa[i], xb[i], 1'b0, xs[i], xm[i]);
        end
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            set_in(xa[i], xb[i], 1'b0, xs[i], xm[i], 1'b1);
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL bp_accept%0d in_ready got=%b exp=1", i, in_ready);
            end
            tick();
        end
        set_in(xa[2], xb[2], 1'b0, xs[2], xm[2], 1'b1);
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || result !== x[0].r || lane_ovf !== x[0].lo) begin
                errors++;
                $display("FAIL bp_hold%0d got in_ready=%b v=%b r=%h lo=%b exp in_ready=0 v=1 r=%h lo=%b",
                         c, in_ready, out_valid, result, lane_ovf, x[0].r, x[0].lo);
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release in_ready got=%b exp=1", in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_valid !== 1'b1 || result !== x[i].r || lane_ovf !== x[i].lo || zero !== x[i].zero) begin
                errors++;
                $display("FAIL bp_drain%0d got v=%b r=%h lo=%b z=%b exp v=1 r=%h lo=%b z=%b",
                         i, out_valid, result, lane_ovf, zero, x[i].r, x[i].lo, x[i].zero);
            end
            tick();
            in_valid = 1'b0;
            #1;
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_empty out_valid got=%b exp=0", out_valid);
        end
        tick();
    endtask

    task automatic test_reset_midflight();
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            set_rand(1'b1);
            tick();
        end
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_full got v=%b in_ready=%b exp v=1 in_ready=0", out_valid, in_ready);
        end
        rst_n = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0 || {result, lane_ovf, ovf, zero, neg} !== 23'd0) begin
            errors++;
            $display("FAIL mid_reset got v=%b r=%h lo=%b o=%b z=%b n=%b exp all 0",
                     out_valid, result, lane_ovf, ovf, zero, neg);
        end
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL mid_stale%0d got v=%b in_ready=%b exp v=0 in_ready=1", c, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_random();
        exp_t e;
        int   full_k;
        q.delete();
        for (int cyc = 0; cyc < 600; cyc++) begin
            full_k = cyc - 300;
            if (full_k >= 0) begin
                set_rand(1'b1);
                out_ready = 1'b1;
            end else begin
                set_rand($urandom_range(0, 3) != 0);
                out_ready = ($urandom_range(0, 3) != 0);
            end
            #1;
            if (full_k >= 0) begin
                checks++;
                if (in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL rnd_thru_in_ready cyc=%0d got=%b exp=1", cyc, in_ready);
                end
                if (full_k >= 2) begin
                    checks++;
                    if (out_valid !== 1'b1) begin
                        errors++;
                        $display("FAIL rnd_bubble cyc=%0d out_valid got=%b exp=1", cyc, out_valid);
                    end
                end
            end
            if (out_valid === 1'b1) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL rnd_spurious cyc=%0d got result=%h exp no beat", cyc, result);
                end else begin
                    e = q[0];
                    if (result !== e.r || lane_ovf !== e.lo || ovf !== e.ovf ||
                        zero !== e.zero || neg !== e.neg) begin
                        errors++;
                        $display("FAIL rnd_beat cyc=%0d got r=%h lo=%b o=%b z=%b n=%b exp r=%h lo=%b o=%b z=%b n=%b",
                                 cyc, result, lane_ovf, ovf, zero, neg, e.r, e.lo, e.ovf, e.zero, e.neg);
                    end
                    if (out_ready) void'(q.pop_front());
                end
            end
            if (in_valid && in_ready === 1'b1) q.push_back(model(a, b, cin, sub, mode));
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 10 && q.size() > 0; c++) begin
            #1;
            checks++;
            e = q[0];
            if (out_valid !== 1'b1 || result !== e.r || lane_ovf !== e.lo) begin
                errors++;
                $display("FAIL rnd_drain got v=%b r=%h lo=%b exp v=1 r=%h lo=%b",
                         out_valid, result, lane_ovf, e.r, e.lo);
            end
            if (out_valid === 1'b1) void'(q.pop_front());
            tick();
        end
        #1;
        checks++;
        if (q.size() != 0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rnd_final got pending=%0d out_valid=%b exp pending=0 out_valid=0", q.size(), out_valid);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_midflight();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
